alu_op_issuer: RTL and testbench

ALU_OP_ISSUER -- requirements
Module: alu_op_issuer

---
 rtl/alu_op_issuer.sv | 171 +++++++++++++++++
 tb/tb_alu_op_issuer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_issuer.sv
// -----------------------------------------------------------------------------
// alu_op_issuer
// Queues ALU operations, drives them one at a time to an external
// combinational ALU, and captures each result with a ready/valid handshake
// towards the consumer.
//
// Pipeline: input FIFO -> issue register -> result register.
//
// Ports
//   clk         rising-edge clock for all state
//   rst         synchronous, active-high reset
//   in_valid    upstream presents an operation
//   in_ready    FIFO has room (count < DEPTH)
//   in_a/in_b   6-bit operands
//   in_sel      opcode: 00 ADD, 01 SUB, 10 MUL, 11 AND
//   alu_a/b/sel operands/opcode to the downstream ALU, from the issue register
//   alu_result  combinational ALU result for alu_a/alu_b/alu_sel
//   out_valid   captured result is available
//   out_ready   consumer takes the result
//   out_result  captured ALU result
//   out_sel     opcode of the captured result
//   out_borrow  SUB with alu_a < alu_b (unsigned)
//   count       current FIFO occupancy
// -----------------------------------------------------------------------------
module alu_op_issuer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [5:0]              in_a,
    input  logic [5:0]              in_b,
    input  logic [1:0]              in_sel,

    output logic [5:0]              alu_a,
    output logic [5:0]              alu_b,
    output logic [1:0]              alu_sel,
    input  logic [11:0]             alu_result,

    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [11:0]             out_result,
    output logic [1:0]              out_sel,
    output logic                    out_borrow,

    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned OPW  = 6;
    localparam int unsigned SELW = 2;
    localparam int unsigned RESW = 12;
    localparam int unsigned ENTW = 2 * OPW + SELW;
    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CW   = PW + 1;

    localparam logic [SELW-1:0] SEL_SUB = 2'b01;

    // FIFO storage and bookkeeping
    logic [ENTW-1:0]  r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Issue stage
    logic             r_iss_v;
    logic [OPW-1:0]   r_alu_a;
    logic [OPW-1:0]   r_alu_b;
    logic [SELW-1:0]  r_alu_sel;

    // Result stage
    logic             r_res_v;
    logic [RESW-1:0]  r_out_result;
    logic [SELW-1:0]  r_out_sel;
    logic             r_out_borrow;

    // Handshake / control
    logic             w_in_ready;
    logic             w_push;
    logic             w_res_load;
    logic             w_iss_load;
    logic             w_borrow;
    logic [ENTW-1:0]  w_wr_entry;
    logic [ENTW-1:0]  w_rd_entry;

    // Control: no full-and-pop bypass, and an empty FIFO never forwards a
    // same-cycle push (issue uses the pre-edge count).
    always_comb begin
        w_in_ready = (r_count < CW'(DEPTH));
        w_push     = in_valid && w_in_ready;
        w_res_load = r_iss_v && (!r_res_v || out_ready);
        w_iss_load = (r_count != '0) && (!r_iss_v || w_res_load);
        w_borrow   = (r_alu_sel == SEL_SUB) && (r_alu_a < r_alu_b);
        w_wr_entry = {in_a, in_b, in_sel};
        w_rd_entry = r_mem[r_rd_ptr];
    end

    // FIFO storage; contents are don't-care once pointers are reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^PW)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_iss_load) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_iss_load})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Issue register; operands hold their last value while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_iss_v   <= 1'b0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_sel <= '0;
        end else if (w_iss_load) begin
            r_iss_v   <= 1'b1;
            r_alu_a   <= w_rd_entry[ENTW-1 -: OPW];
            r_alu_b   <= w_rd_entry[SELW +: OPW];
            r_alu_sel <= w_rd_entry[SELW-1:0];
        end else if (w_res_load) begin
            r_iss_v   <= 1'b0;
        end
    end

    // Result register; payload only changes on a load, so it holds under stall
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_v      <= 1'b0;
            r_out_result <= '0;
            r_out_sel    <= '0;
            r_out_borrow <= 1'b0;
        end else if (w_res_load) begin
            r_res_v      <= 1'b1;
            r_out_result <= alu_result;
            r_out_sel    <= r_alu_sel;
            r_out_borrow <= w_borrow;
        end else if (out_ready) begin
            r_res_v      <= 1'b0;
        end
    end

    assign in_ready   = w_in_ready;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_sel    = r_alu_sel;
    assign out_valid  = r_res_v;
    assign out_result = r_out_result;
    assign out_sel    = r_out_sel;
    assign out_borrow = r_out_borrow;
    assign count      = r_count;

endmodule

// File: tb/tb_alu_op_issuer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_issuer
// Directed bench for alu_op_issuer with a behavioural combinational ALU
// attached to the alu_* ports.
// -----------------------------------------------------------------------------
module tb_alu_op_issuer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [5:0]     in_a;
    logic [5:0]     in_b;
    logic [1:0]     in_sel;
    logic [5:0]     alu_a;
    logic [5:0]     alu_b;
    logic [1:0]     alu_sel;
    logic [11:0]    alu_result;
    logic           out_valid;
    logic           out_ready;
    logic [11:0]    out_result;
    logic [1:0]     out_sel;
    logic           out_borrow;
    logic [CW-1:0]  count;

    int n_checks;
    int n_errors;

    alu_op_issuer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_sel     (in_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_sel    (out_sel),
        .out_borrow (out_borrow),
        .count      (count)
    );

    // Downstream ALU model
    always_comb begin
        alu_result = '0;
        case (alu_sel)
            2'b00:   alu_result = 12'(alu_a) + 12'(alu_b);
            2'b01:   alu_result = 12'(alu_a) - 12'(alu_b);
            2'b10:   alu_result = 12'(alu_a) * 12'(alu_b);
            default: alu_result = 12'(alu_a & alu_b);
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] a, input logic [5:0] b, input logic [1:0] s);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_sel   = s;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 6'd0, 6'd0, 2'b00);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_count",     32'(count),      32'd0);
        check("rst_in_ready",  32'(in_ready),   32'd1);
        check("rst_out_valid", 32'(out_valid),  32'd0);
        check("rst_alu_a",     32'(alu_a),      32'd0);
        check("rst_out_res",   32'(out_result), 32'd0);

        // Single op 15 + 5: issue at N+1, result at N+2
        drive(1'b1, 6'd15, 6'd5, 2'b00);
        tick();
        drive(1'b0, 6'd0, 6'd0, 2'b00);
        check("single_n_count", 32'(count),     32'd1);
        check("single_n_ov",    32'(out_valid), 32'd0);
        tick();
        check("single_n1_alu_a", 32'(alu_a),     32'd15);
        check("single_n1_alu_b", 32'(alu_b),     32'd5);
        check("single_n1_count", 32'(count),     32'd0);
        check("single_n1_ov",    32'(out_valid), 32'd0);
        tick();
        check("single_n2_ov",     32'(out_valid),  32'd1);
        check("single_n2_res",    32'(out_result), 32'd20);
        check("single_n2_sel",    32'(out_sel),    32'd0);
        check("single_n2_borrow", 32'(out_borrow), 32'd0);
        check("single_n2_count",  32'(count),      32'd0);
        tick();
        check("single_drained", 32'(out_valid), 32'd0);

        // Stream of four ops pushed back to back
        drive(1'b1, 6'd30, 6'd10, 2'b01);
        tick();
        drive(1'b1, 6'd6, 6'd7, 2'b10);
        tick();
        drive(1'b1, 6'd42, 6'd51, 2'b11);
        tick();
        check("stream_r0", 32'(out_result), 32'd20);
        check("stream_s0", 32'(out_sel),    32'd1);
        check("stream_v0", 32'(out_valid),  32'd1);
        drive(1'b1, 6'd63, 6'd1, 2'b00);
        tick();
        drive(1'b0, 6'd0, 6'd0, 2'b00);
        check("stream_r1", 32'(out_result), 32'd42);
        check("stream_v1", 32'(out_valid),  32'd1);
        tick();
        check("stream_r2", 32'(out_result), 32'd34);
        check("stream_v2", 32'(out_valid),  32'd1);
        tick();
        check("stream_r3", 32'(out_result), 32'd64);
        check("stream_v3", 32'(out_valid),  32'd1);
        tick();
        check("stream_done", 32'(out_valid), 32'd0);

        // Backpressure: six ops (k + 1) fill result, issue and all FIFO slots
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, 6'(k), 6'd1, 2'b00);
            tick();
        end
        check("bp_count",    32'(count),      32'd4);
        check("bp_in_ready", 32'(in_ready),   32'd0);
        check("bp_ov",       32'(out_valid),  32'd1);
        check("bp_res",      32'(out_result), 32'd2);
        check("bp_alu_a",    32'(alu_a),      32'd2);

        // Seventh op offered while full; stall must hold everything for 5 cycles
        drive(1'b1, 6'd50, 6'd9, 2'b01);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("hold_count",  32'(count),      32'd4);
            check("hold_res",    32'(out_result), 32'd2);
            check("hold_sel",    32'(out_sel),    32'd0);
            check("hold_borrow", 32'(out_borrow), 32'd0);
            check("hold_alu_a",  32'(alu_a),      32'd2);
            check("hold_alu_b",  32'(alu_b),      32'd1);
            check("hold_alu_s",  32'(alu_sel),    32'd0);
        end
        drive(1'b0, 6'd0, 6'd0, 2'b00);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("drain_ov",  32'(out_valid),  32'd1);
            check("drain_res", 32'(out_result), 32'(3 + k));
        end
        tick();
        check("drain_done_ov",    32'(out_valid), 32'd0);
        check("drain_done_count", 32'(count),     32'd0);

        // Borrow flag and largest product
        drive(1'b1, 6'd0, 6'd1, 2'b01);
        tick();
        drive(1'b1, 6'd63, 6'd63, 2'b10);
        tick();
        drive(1'b0, 6'd0, 6'd0, 2'b00);
        tick();
        check("borrow_res", 32'(out_result), 32'hFFF);
        check("borrow_sel", 32'(out_sel),    32'd1);
        check("borrow_flg", 32'(out_borrow), 32'd1);
        tick();
        check("mul_res", 32'(out_result), 32'd3969);
        check("mul_sel", 32'(out_sel),    32'd2);
        check("mul_flg", 32'(out_borrow), 32'd0);
        tick();
        check("mul_done", 32'(out_valid), 32'd0);

        // Reset mid-run with count=3 and both stages occupied
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 6'd3, 6'd9, 2'b01);
            tick();
        end
        drive(1'b0, 6'd0, 6'd0, 2'b00);
        check("pre_rst_count",  32'(count),      32'd3);
        check("pre_rst_ov",     32'(out_valid),  32'd1);
        check("pre_rst_borrow", 32'(out_borrow), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_count",  32'(count),      32'd0);
        check("mid_rst_ov",     32'(out_valid),  32'd0);
        check("mid_rst_ready",  32'(in_ready),   32'd1);
        check("mid_rst_alu_a",  32'(alu_a),      32'd0);
        check("mid_rst_alu_b",  32'(alu_b),      32'd0);
        check("mid_rst_alu_s",  32'(alu_sel),    32'd0);
        check("mid_rst_res",    32'(out_result), 32'd0);
        check("mid_rst_sel",    32'(out_sel),    32'd0);
        check("mid_rst_borrow", 32'(out_borrow), 32'd0);

        // Fresh push after reset follows the normal latency
        out_ready = 1'b1;
        drive(1'b1, 6'd15, 6'd5, 2'b00);
        tick();
        drive(1'b0, 6'd0, 6'd0, 2'b00);
        check("post_rst_n_count", 32'(count),     32'd1);
        check("post_rst_n_ov",    32'(out_valid), 32'd0);
        tick();
        check("post_rst_n1_alu_a", 32'(alu_a),     32'd15);
        check("post_rst_n1_ov",    32'(out_valid), 32'd0);
        tick();
        check("post_rst_n2_ov",  32'(out_valid),  32'd1);
        check("post_rst_n2_res", 32'(out_result), 32'd20);
        tick();
        check("post_rst_done", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
